// File: rtl/mac_sched_pkg.sv
// Shared types for the mac_dot_sched scheduler: FSM states, requester id, accumulator width helper.
package mac_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      RESULT
   } state_t;

   typedef logic req_id_t;

   localparam int unsigned NUM_REQ = 2;

   function automatic int unsigned acc_w(input int unsigned dw);
      return 3 * dw;
   endfunction

   localparam int unsigned ACC_W = acc_w(8);

endpackage

// File: rtl/mac_sched_dp.sv
// Two-stage MAC datapath: operand registers then a clear/enable-gated accumulator.
// MAC_SAT_EN selects a saturating accumulator instead of modulo wrap.
module mac_sched_dp
   import mac_sched_pkg::*;
#(
   parameter int unsigned DWIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  ld_i,
   input  logic [DWIDTH-1:0]     a_i,
   input  logic [DWIDTH-1:0]     b_i,
   output logic [3*DWIDTH-1:0]   acc_o
);

   localparam int unsigned AW = acc_w(DWIDTH);

   logic [DWIDTH-1:0]   a_q, b_q;
   logic                mul_en_q;
   logic [AW-1:0]       acc_q, acc_d;
   logic [2*DWIDTH-1:0] prod;

   assign prod = a_q * b_q;

`ifdef MAC_SAT_EN
   logic [AW:0] sum;

   // Products are never negative, so once the sum clips it stays at full scale until the next clear.
   always_comb begin
      sum   = {1'b0, acc_q} + {{(DWIDTH + 1){1'b0}}, prod};
      acc_d = sum[AW] ? '1 : sum[AW-1:0];
   end
`else
   always_comb begin
      acc_d = acc_q + {{DWIDTH{1'b0}}, prod};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         mul_en_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         if (ld_i) begin
            a_q <= a_i;
            b_q <= b_i;
         end
         mul_en_q <= ld_i & ~clr_i;
         if (clr_i) begin
            acc_q <= '0;
         end else if (mul_en_q) begin
            acc_q <= acc_d;
         end
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mac_dot_sched.sv
// Two-requester dot-product scheduler: round-robin job grant, beat counter and FSM around mac_sched_dp.
// Build with MAC_SAT_EN defined for a saturating accumulator.
module mac_dot_sched
   import mac_sched_pkg::*;
#(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned LEN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   input  logic [2*LEN_W-1:0]    req_len,
   output logic [1:0]            req_ready,
   input  logic [1:0]            op_valid,
   input  logic [2*DWIDTH-1:0]   op_a,
   input  logic [2*DWIDTH-1:0]   op_b,
   output logic [1:0]            op_ready,
   output logic                  res_valid,
   output logic [3*DWIDTH-1:0]   res_data,
   output logic                  res_id,
   input  logic                  res_ready,
   output logic                  busy
);

   state_t           state_q;
   req_id_t          id_q;
   req_id_t          last_grant_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic             res_valid_q;

   logic [1:0]       gnt_d;
   req_id_t          gnt_id_d;
   logic             gnt_fire;
   logic [LEN_W-1:0] len_d;
   logic [LEN_W-1:0] cnt_d;
   logic             op_fire;
   logic [DWIDTH-1:0] a_d, b_d;

   // Round-robin: on a tie the requester that did not win last time is granted.
   always_comb begin
      gnt_d = '0;
      if (state_q == IDLE && !rst) begin
         case (req_valid)
            2'b01:   gnt_d = 2'b01;
            2'b10:   gnt_d = 2'b10;
            2'b11:   gnt_d = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_d = 2'b00;
         endcase
      end
   end

   assign gnt_id_d  = gnt_d[1];
   assign gnt_fire  = |gnt_d;
   assign len_d     = gnt_id_d ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
   assign req_ready = gnt_d;

   assign op_ready = (state_q == RUN) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
   assign op_fire  = |(op_valid & op_ready);
   assign a_d      = id_q ? op_a[2*DWIDTH-1:DWIDTH] : op_a[DWIDTH-1:0];
   assign b_d      = id_q ? op_b[2*DWIDTH-1:DWIDTH] : op_b[DWIDTH-1:0];
   assign cnt_d    = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         len_q        <= '0;
         cnt_q        <= '0;
         res_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_fire) begin
                  id_q         <= gnt_id_d;
                  last_grant_q <= gnt_id_d;
                  len_q        <= len_d;
                  cnt_q        <= '0;
                  if (len_d != '0) begin
                     state_q <= RUN;
                  end else begin
                     state_q     <= RESULT;
                     res_valid_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (op_fire) begin
                  cnt_q <= cnt_d;
                  if (cnt_d == len_q) state_q <= DRAIN;
               end
            end
            // One cycle for the final product to land in the accumulator.
            DRAIN: begin
               state_q     <= RESULT;
               res_valid_q <= 1'b1;
            end
            RESULT: begin
               if (res_ready) begin
                  state_q     <= IDLE;
                  res_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   mac_sched_dp #(
      .DWIDTH (DWIDTH)
   ) u_dp (
      .clk   (clk),
      .rst   (rst),
      .clr_i (gnt_fire),
      .ld_i  (op_fire),
      .a_i   (a_d),
      .b_i   (b_d),
      .acc_o (res_data)
   );

   assign res_valid = res_valid_q;
   assign res_id    = id_q;
   assign busy      = (state_q != IDLE);

endmodule
